// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: state encoding,
// opcode constants, field widths and the watchdog limit.
package seq_pkg;

   localparam int ADDR_W     = 8;
   localparam int INSTR_W    = 16;
   localparam int OP_W       = 4;
   localparam int PARAM_W    = 6;
   localparam int RETIRE_W   = 16;
   localparam int WDOG_W     = 6;
   localparam int WDOG_LIMIT = 32;

   localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
   localparam logic [OP_W-1:0] OP_JUMP = 4'hE;
   localparam logic [OP_W-1:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT_MEM,
      ST_DECODE,
      ST_ISSUE,
      ST_WAIT_DONE,
      ST_HALT,
      ST_ERROR
   } seqState_e;

   // The sequencer counts as busy everywhere except its three resting states.
   function automatic logic isActiveState(input seqState_e s);
      return !((s == ST_IDLE) || (s == ST_HALT) || (s == ST_ERROR));
   endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Cycle counter guarding the wait for ALU completion. Cleared when the
// sequencer enters WAIT_DONE, counts each WAIT_DONE cycle, and flags expiry
// during the cycle in which the count would reach WDOG_LIMIT.
module seq_watchdog
   import seq_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic countEn_i,
   output logic expire_o
);

   logic [WDOG_W-1:0] count_q;

   // Count WAIT_DONE cycles; clear has priority and the count saturates at the limit.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (countEn_i && (count_q != WDOG_W'(WDOG_LIMIT))) begin
         count_q <= count_q + WDOG_W'(1);
      end
   end

   assign expire_o = countEn_i && (count_q == WDOG_W'(WDOG_LIMIT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 16-bit words from program memory, handles
// NOP/JUMP/HALT locally and dispatches everything else to an ALU sequencer,
// waiting for its completion pulse before moving on.
// Optional feature macro: SEQ_WATCHDOG_EN adds a completion watchdog that
// moves the sequencer into a sticky ERROR state when the ALU never answers.
module instr_sequencer
   import seq_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  run,
   input  logic [INSTR_W-1:0]    instr_data,
   input  logic                  alu_done,
   output logic [ADDR_W-1:0]     instr_addr,
   output logic                  instr_rd_en,
   output logic                  alu_start,
   output logic [OP_W-1:0]       alu_opcode,
   output logic [PARAM_W-1:0]    alu_param1,
   output logic [PARAM_W-1:0]    alu_param2,
   output logic                  busy,
   output logic                  halted,
   output logic                  error,
   output logic [RETIRE_W-1:0]   retired
);

   seqState_e             state_q, state_d;
   logic [ADDR_W-1:0]     pc_q, pc_d;
   logic [INSTR_W-1:0]    ir_q, ir_d;
   logic [RETIRE_W-1:0]   retired_q, retired_d;
   logic                  rdEn_q;
   logic                  aluStart_q;
   logic [OP_W-1:0]       aluOpcode_q;
   logic [PARAM_W-1:0]    aluParam1_q;
   logic [PARAM_W-1:0]    aluParam2_q;
   logic                  busy_q;
   logic                  halted_q;
   seqState_e             nextState;
   logic                  wdogExpire;

   // After a retirement the sequencer keeps going only while run is held.
   assign nextState = run ? ST_FETCH : ST_IDLE;

`ifdef SEQ_WATCHDOG_EN
   logic error_q;

   seq_watchdog uWatchdog (
      .clock     (clock),
      .reset     (reset),
      .clear_i   ((state_d == ST_WAIT_DONE) && (state_q != ST_WAIT_DONE)),
      .countEn_i (state_q == ST_WAIT_DONE),
      .expire_o  (wdogExpire)
   );

   assign error = error_q;
`else
   assign wdogExpire = 1'b0;
   assign error      = 1'b0;
`endif

   // Next-state, program counter, instruction register and retire counter updates.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      retired_d = retired_q;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            state_d = ST_WAIT_MEM;
         end
         ST_WAIT_MEM: begin
            ir_d    = instr_data;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            case (ir_q[15:12])
               OP_NOP: begin
                  pc_d      = pc_q + ADDR_W'(1);
                  retired_d = retired_q + RETIRE_W'(1);
                  state_d   = nextState;
               end
               OP_JUMP: begin
                  pc_d      = ir_q[ADDR_W-1:0];
                  retired_d = retired_q + RETIRE_W'(1);
                  state_d   = nextState;
               end
               OP_HALT: begin
                  pc_d      = pc_q + ADDR_W'(1);
                  retired_d = retired_q + RETIRE_W'(1);
                  state_d   = ST_HALT;
               end
               default: begin
                  state_d = ST_ISSUE;
               end
            endcase
         end
         ST_ISSUE: begin
            state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (alu_done) begin
               pc_d      = pc_q + ADDR_W'(1);
               retired_d = retired_q + RETIRE_W'(1);
               state_d   = nextState;
            end else if (wdogExpire) begin
               state_d = ST_ERROR;
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase
   end

   // State and every output are registered; outputs reflect the state being entered.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pc_q        <= '0;
         ir_q        <= '0;
         retired_q   <= '0;
         rdEn_q      <= 1'b0;
         aluStart_q  <= 1'b0;
         aluOpcode_q <= '0;
         aluParam1_q <= '0;
         aluParam2_q <= '0;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
         error_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         retired_q  <= retired_d;
         rdEn_q     <= (state_d == ST_FETCH);
         aluStart_q <= (state_d == ST_ISSUE);
         if ((state_q == ST_DECODE) && (state_d == ST_ISSUE)) begin
            aluOpcode_q <= ir_q[15:12];
            aluParam1_q <= ir_q[11:6];
            aluParam2_q <= ir_q[5:0];
         end
         busy_q     <= isActiveState(state_d);
         halted_q   <= (state_d == ST_HALT);
`ifdef SEQ_WATCHDOG_EN
         error_q    <= (state_d == ST_ERROR);
`endif
      end
   end

   assign instr_addr  = pc_q;
   assign instr_rd_en = rdEn_q;
   assign alu_start   = aluStart_q;
   assign alu_opcode  = aluOpcode_q;
   assign alu_param1  = aluParam1_q;
   assign alu_param2  = aluParam2_q;
   assign busy        = busy_q;
   assign halted      = halted_q;
   assign retired     = retired_q;

endmodule
